// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encodings and the default operand width.
package divider_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_ripple.sv
// N-bit ripple-borrow subtractor: diff_o = a_i - b_i, borrow_o set when a_i < b_i.
module sub_ripple #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  // Bit-serial borrow chain, LSB to MSB
  always_comb begin
    logic brw_s;
    brw_s    = 1'b0;
    diff_o   = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      diff_o[i] = a_i[i] ^ b_i[i] ^ brw_s;
      brw_s     = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw_s);
    end
    borrow_o = brw_s;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Results are held in output registers that change only on entry to DONE.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   part_q, part_d;   // running partial remainder
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, done_q;

  logic [WIDTH:0]     trial_a_s;
  logic [WIDTH:0]     trial_b_s;
  logic [WIDTH:0]     diff_s;
  logic               borrow_s;
  logic               q_bit_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic               diff_msb_unused_s;

  assign trial_a_s  = {part_q, work_q[WIDTH-1]};
  assign trial_b_s  = {1'b0, dvs_q};

  sub_ripple #(.N(WIDTH + 1)) u_sub (
    .a_i      (trial_a_s),
    .b_i      (trial_b_s),
    .diff_o   (diff_s),
    .borrow_o (borrow_s)
  );

  // Partial < 2*divisor, so a successful trial always fits in WIDTH bits
  assign q_bit_s           = ~borrow_s;
  assign rem_next_s        = borrow_s ? trial_a_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
  assign diff_msb_unused_s = diff_s[WIDTH];

  // Next-state, datapath and result-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    part_d  = part_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d = dividend;
          dvs_d  = divisor;
          cnt_d  = {CNT_W{1'b0}};
          part_d = {WIDTH{1'b0}};
          if (divisor == {WIDTH{1'b0}}) begin
            state_d = ST_DONE;
            quot_d  = {WIDTH{1'b1}};
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        work_d = {work_q[WIDTH-2:0], q_bit_s};
        part_d = rem_next_s;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          quot_d  = {work_q[WIDTH-2:0], q_bit_s};
          rem_d   = rem_next_s;
          dbz_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      work_q  <= {WIDTH{1'b0}};
      part_q  <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      part_q  <= part_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) against a plain-arithmetic division model.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : W'(a / b);
  endfunction

  function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : W'(a % b);
  endfunction

  // Issue one operation from IDLE; lat = cycle index (acceptance edge = T) of done
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit busy_seen);
    start = 1'b0;
    step();
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    lat = 1;
    busy_seen = busy;
    while (!done && lat < 30) begin
      step();
      lat++;
      if (busy) busy_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {2'b00, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8] = '{8'd100, 8'd255, 8'd5, 8'd200, 8'd37, 8'd0, 8'd255, 8'd13};
    logic [W-1:0] tb [8] = '{8'd7,   8'd1,   8'd9, 8'd200, 8'd0,  8'd3, 8'd255, 8'd0};
    int lat; bit bs;
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] a, b;
      if (i < 8) begin a = ta[i]; b = tb[i]; end
      else begin a = W'($urandom); b = W'($urandom_range(1, 255)); end
      run_op(a, b, lat, bs);
      n_checks++;
      if (lat != ((b == 0) ? 1 : W + 1)) begin
        n_fail++; $display("FAIL latency %0d/%0d: got %0d, want %0d", a, b, lat, (b == 0) ? 1 : W + 1);
      end
      n_checks++;
      if (quotient !== model_q(a, b) || remainder !== model_r(a, b)) begin
        n_fail++; $display("FAIL result %0d/%0d: got %0d r %0d, want %0d r %0d",
                           a, b, quotient, remainder, model_q(a, b), model_r(a, b));
      end
      n_checks++;
      if (div_by_zero !== (b == 0) || bs !== (b != 0)) begin
        n_fail++; $display("FAIL flags %0d/%0d: got dbz=%b busy_seen=%b, want dbz=%b busy_seen=%b",
                           a, b, div_by_zero, bs, b == 0, b != 0);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat; bit bs;
    start = 1'b0; step();
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();                                   // accepted at T
    start = 1'b0; dividend = 8'd1; divisor = 8'd1;
    step(); step();
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    step();                                   // start pulse in RUN at T+3
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat = 0;
    while (!done && lat < 30) begin step(); lat++; end
    n_checks++;
    if (!done || quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL ignore_start: got done=%b %0d r %0d dbz=%b, want 14 r 2 dbz=0",
                         done, quotient, remainder, div_by_zero);
    end
    run_op(8'd50, 8'd5, lat, bs);
    n_checks++;
    if (quotient !== 8'd10 || remainder !== 8'd0 || lat != W + 1) begin
      n_fail++; $display("FAIL after_ignore: got %0d r %0d lat %0d, want 10 r 0 lat %0d",
                         quotient, remainder, lat, W + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit bs; bit saw_done;
    start = 1'b0; step();
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();                                   // accepted at T
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();                                   // reset edge T+4
    rst_n = 1'b1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {2'b00, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                         busy, done, quotient, remainder, div_by_zero);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (done || busy) saw_done = 1'b1; end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL mid_reset_abort: got activity after reset, want none");
    end
    run_op(8'd9, 8'd2, lat, bs);
    n_checks++;
    if (quotient !== 8'd4 || remainder !== 8'd1 || lat != W + 1) begin
      n_fail++; $display("FAIL post_reset_op: got %0d r %0d lat %0d, want 4 r 1 lat %0d",
                         quotient, remainder, lat, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int cnt, exp_cnt;
    start = 1'b0; step(); step();
    for (int k = 0; k < 1000; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = W'($urandom);
      b = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : W'($urandom_range(1, 255));
      dividend = a; divisor = b; start = 1'b1;
      cnt = 0;
      do begin step(); cnt++; end while (!done && cnt < 30);
      exp_cnt = ((k == 0) ? 1 : 2) + ((b == 0) ? 0 : W);
      n_checks++;
      if (cnt != exp_cnt) begin
        n_fail++; $display("FAIL b2b_spacing op %0d (%0d/%0d): got %0d, want %0d", k, a, b, cnt, exp_cnt);
        if (!done) break;
      end
      n_checks++;
      if (quotient !== model_q(a, b) || remainder !== model_r(a, b) || div_by_zero !== (b == 0)) begin
        n_fail++; $display("FAIL b2b_result op %0d (%0d/%0d): got %0d r %0d dbz=%b, want %0d r %0d dbz=%b",
                           k, a, b, quotient, remainder, div_by_zero, model_q(a, b), model_r(a, b), b == 0);
      end
    end
    start = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
